traffic_light_ctrl: RTL

Parametrised two-approach intersection controller, the next generation of the fixed-timing NS/EW light. It adds configurable green, yellow, all-red and walk durations, and a mandatory all-red clearance between conflicting greens. It also adds a latched pedestrian-walk request and a maintenance flashing-yellow mode. It sits behind the shared 1 Hz `tick` pulse generator and drives the lamp and walk-signal outputs directly.

---
 rtl/traffic_light_ctrl_if.sv | 28 ++
 rtl/traffic_light_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the tick/request side and the intersection controller.
interface traffic_light_ctrl_if;
    localparam int unsigned PHASE_W = 3;

    logic               tick;
    logic               ped_req;
    logic               flash_mode;
    logic               ns_g;
    logic               ns_y;
    logic               ns_r;
    logic               ew_g;
    logic               ew_y;
    logic               ew_r;
    logic               walk;
    logic [PHASE_W-1:0] phase;

    // Driver side: tick generator, pedestrian button, maintenance switch
    modport master (
        output tick, ped_req, flash_mode,
        input  ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, phase
    );

    // Controller side
    modport slave (
        input  tick, ped_req, flash_mode,
        output ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, phase
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-approach intersection controller: timed NS/EW greens with all-red
// clearance, latched pedestrian walk phase and maintenance flashing yellow.
module traffic_light_ctrl #(
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 3,
    parameter int unsigned CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_light_ctrl_if.slave  if_lights
);

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned LAMP_W  = 7;

    // Lamp vector bit positions: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk}
    localparam int unsigned L_NS_G = 6;
    localparam int unsigned L_NS_Y = 5;
    localparam int unsigned L_NS_R = 4;
    localparam int unsigned L_EW_G = 3;
    localparam int unsigned L_EW_Y = 2;
    localparam int unsigned L_EW_R = 1;
    localparam int unsigned L_WALK = 0;

    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);

    typedef enum logic [PHASE_W-1:0] {
        ST_NS_G    = 3'd0,
        ST_NS_Y    = 3'd1,
        ST_EW_G    = 3'd2,
        ST_EW_Y    = 3'd3,
        ST_ALL_RED = 3'd4,
        ST_WALK    = 3'd5,
        ST_FLASH   = 3'd6,
        ST_ILLEGAL = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt;
    logic [CNT_W-1:0]    w_last_cnt;
    logic                r_next_dir;
    logic                w_next_dir;
    logic                r_ped_pending;
    logic                w_ped_pending;
    logic                r_blink;
    logic                w_blink;
    logic [LAMP_W-1:0]   r_lamps;
    logic [LAMP_W-1:0]   w_lamps;

    // Terminal count of the current timed state
    always_comb begin
        w_last_cnt = ALLRED_LAST;
        case (r_state)
            ST_NS_G, ST_EW_G: w_last_cnt = GREEN_LAST;
            ST_NS_Y, ST_EW_Y: w_last_cnt = YELLOW_LAST;
            ST_WALK:          w_last_cnt = WALK_LAST;
            default:          w_last_cnt = ALLRED_LAST;
        endcase
    end

    // Next-state, phase counter, direction, request latch and blink
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_next_dir    = r_next_dir;
        w_blink       = r_blink;
        w_ped_pending = r_ped_pending | if_lights.ped_req;

        if (r_state == ST_ILLEGAL) begin
            w_state = ST_ALL_RED;
        end else if (if_lights.tick) begin
            if (r_state == ST_FLASH) begin
                if (!if_lights.flash_mode) begin
                    w_state    = ST_ALL_RED;
                    w_next_dir = 1'b0;
                end else begin
                    w_blink = ~r_blink;
                end
            end else if (r_cnt != w_last_cnt) begin
                w_cnt = r_cnt + CNT_W'(1);
            end else begin
                case (r_state)
                    ST_NS_G: w_state = ST_NS_Y;
                    ST_NS_Y: begin
                        w_state    = ST_ALL_RED;
                        w_next_dir = 1'b1;
                    end
                    ST_EW_G: w_state = ST_EW_Y;
                    ST_EW_Y: begin
                        w_state    = ST_ALL_RED;
                        w_next_dir = 1'b0;
                    end
                    ST_ALL_RED: begin
                        if (if_lights.flash_mode) begin
                            w_state = ST_FLASH;
                        end else if (r_ped_pending) begin
                            w_state = ST_WALK;
                        end else if (!r_next_dir) begin
                            w_state = ST_NS_G;
                        end else begin
                            w_state = ST_EW_G;
                        end
                    end
                    ST_WALK: w_state = r_next_dir ? ST_EW_G : ST_NS_G;
                    default: w_state = ST_ALL_RED;
                endcase
            end
        end

        // Entry actions; a request arriving on the WALK entry cycle stays latched
        if (w_state != r_state) begin
            w_cnt = '0;
            if (w_state == ST_WALK) begin
                w_ped_pending = if_lights.ped_req;
            end
            if (w_state == ST_FLASH) begin
                w_blink = 1'b1;
            end
        end
    end

    // Lamp decode of the upcoming state, so registered lamps track the state register
    always_comb begin
        w_lamps = '0;
        case (w_state)
            ST_NS_G: begin
                w_lamps[L_NS_G] = 1'b1;
                w_lamps[L_EW_R] = 1'b1;
            end
            ST_NS_Y: begin
                w_lamps[L_NS_Y] = 1'b1;
                w_lamps[L_EW_R] = 1'b1;
            end
            ST_EW_G: begin
                w_lamps[L_EW_G] = 1'b1;
                w_lamps[L_NS_R] = 1'b1;
            end
            ST_EW_Y: begin
                w_lamps[L_EW_Y] = 1'b1;
                w_lamps[L_NS_R] = 1'b1;
            end
            ST_WALK: begin
                w_lamps[L_NS_R] = 1'b1;
                w_lamps[L_EW_R] = 1'b1;
                w_lamps[L_WALK] = 1'b1;
            end
            ST_FLASH: begin
                w_lamps[L_NS_Y] = w_blink;
                w_lamps[L_EW_Y] = w_blink;
            end
            default: begin
                w_lamps[L_NS_R] = 1'b1;
                w_lamps[L_EW_R] = 1'b1;
            end
        endcase
    end

    // State and output registers, synchronous reset to all-red
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_ALL_RED;
            r_cnt         <= '0;
            r_next_dir    <= 1'b0;
            r_ped_pending <= 1'b0;
            r_blink       <= 1'b0;
            r_lamps       <= LAMP_W'(7'b0010010);
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_next_dir    <= w_next_dir;
            r_ped_pending <= w_ped_pending;
            r_blink       <= w_blink;
            r_lamps       <= w_lamps;
        end
    end

    assign if_lights.ns_g  = r_lamps[L_NS_G];
    assign if_lights.ns_y  = r_lamps[L_NS_Y];
    assign if_lights.ns_r  = r_lamps[L_NS_R];
    assign if_lights.ew_g  = r_lamps[L_EW_G];
    assign if_lights.ew_y  = r_lamps[L_EW_Y];
    assign if_lights.ew_r  = r_lamps[L_EW_R];
    assign if_lights.walk  = r_lamps[L_WALK];
    assign if_lights.phase = r_state;

endmodule
